alu_arbiter: RTL and testbench

- Time-shares the single combinational execute ALU between two requesters: port 0 is the pipeline issue path and port 1 is the auxiliary path (branch-target/debug).
- Round-robin arbitration with valid/ready handshakes on each request port.
- Drives the ALU operand/opcode fields and captures the ALU result into a one-entry response register tagged with the requester ID.
- Sits between decode and execute-to-memory; the ALU itself is unchanged.

---
 rtl/alu_arbiter_pkg.sv | 32 +++
 rtl/alu_arbiter_if.sv | 57 +++++
 rtl/alu_arbiter_rr_arb2.sv | 29 ++
 rtl/alu_arbiter.sv | 115 +++++++++++
 tb/tb_alu_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-port execute-ALU arbiter.
// Also carries the saturating counter helper used by the optional perf counters.
package alu_arbiter_pkg;

   localparam int ALU_W = 32;

   localparam logic [6:0] OPCODE_OP     = 7'b0110011;
   localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
   localparam logic [2:0] F3_ADD_SUB    = 3'b000;
   localparam logic [2:0] F3_XOR        = 3'b100;
   localparam logic [6:0] F7_BASE       = 7'b0000000;
   localparam logic [6:0] F7_ALT        = 7'b0100000;

   typedef enum logic {
      ARB_ID_PIPE = 1'b0,
      ARB_ID_AUX  = 1'b1
   } arb_id_e;

   typedef struct packed {
      logic [6:0]       opcode;
      logic [2:0]       funct3;
      logic [6:0]       funct7;
      logic [ALU_W-1:0] a;
      logic [ALU_W-1:0] b;
   } alu_req_t;

   function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
      if (inc && (v != 16'hFFFF)) return v + 16'd1;
      return v;
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request, ALU and response signal bundle for alu_arbiter.
// slave is the arbiter's view; master is the requester/ALU/consumer side.
interface alu_arbiter_if #(
   parameter int N = 32
);
   import alu_arbiter_pkg::*;

   logic         req0_valid;
   logic         req0_ready;
   logic [6:0]   req0_opcode;
   logic [2:0]   req0_funct3;
   logic [6:0]   req0_funct7;
   logic [N-1:0] req0_a;
   logic [N-1:0] req0_b;

   logic         req1_valid;
   logic         req1_ready;
   logic [6:0]   req1_opcode;
   logic [2:0]   req1_funct3;
   logic [6:0]   req1_funct7;
   logic [N-1:0] req1_a;
   logic [N-1:0] req1_b;

   logic [6:0]   alu_opcode;
   logic [2:0]   alu_funct3;
   logic [6:0]   alu_funct7;
   logic [N-1:0] alu_a;
   logic [N-1:0] alu_b;
   logic         alu_valid;
   logic [N-1:0] alu_result;
   logic         alu_zero;

   logic         rsp_valid;
   logic         rsp_ready;
   arb_id_e      rsp_id;
   logic [N-1:0] rsp_result;
   logic         rsp_zero;

   modport slave (
      input  req0_valid, req0_opcode, req0_funct3, req0_funct7, req0_a, req0_b,
      input  req1_valid, req1_opcode, req1_funct3, req1_funct7, req1_a, req1_b,
      input  alu_result, alu_zero, rsp_ready,
      output req0_ready, req1_ready,
      output alu_opcode, alu_funct3, alu_funct7, alu_a, alu_b, alu_valid,
      output rsp_valid, rsp_id, rsp_result, rsp_zero
   );

   modport master (
      output req0_valid, req0_opcode, req0_funct3, req0_funct7, req0_a, req0_b,
      output req1_valid, req1_opcode, req1_funct3, req1_funct7, req1_a, req1_b,
      output alu_result, alu_zero, rsp_ready,
      input  req0_ready, req1_ready,
      input  alu_opcode, alu_funct3, alu_funct7, alu_a, alu_b, alu_valid,
      input  rsp_valid, rsp_id, rsp_result, rsp_zero
   );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant with its priority pointer.
// The pointer flips to the other port after every accepted grant.
module rr_arb2
   import alu_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       en,
   output logic       gnt_valid,
   output arb_id_e    gnt_id
);

   logic prio;

   always_comb begin
      gnt_id = ARB_ID_PIPE;
      if (req == 2'b11) gnt_id = arb_id_e'(prio);
      else if (req[1])  gnt_id = ARB_ID_AUX;
   end

   assign gnt_valid = en && (|req);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         prio <= 1'b0;
      else if (gnt_valid) prio <= ~gnt_id;
   end

endmodule

// File: rtl/alu_arbiter.sv
// Time-shares the execute ALU between the pipeline (port 0) and aux (port 1) paths.
// Optional perf counters are built when ALU_ARB_PERF_EN is defined.
//
// state     | meaning
// RSP_EMPTY | response register holds nothing; any grant is accepted
// RSP_FULL  | response held stable until rsp_ready; refill allowed on drain
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int N = ALU_W
) (
   input  logic        clk,
   input  logic        rst_n,
`ifdef ALU_ARB_PERF_EN
   input  logic        perf_clr,
   output logic [15:0] perf_grant0,
   output logic [15:0] perf_grant1,
   output logic [15:0] perf_conflict,
`endif
   alu_arbiter_if.slave bus
);

   typedef enum logic {RSP_EMPTY, RSP_FULL} rsp_state_e;

   rsp_state_e   state, state_nxt;
   logic         can_accept;
   logic         accept;
   arb_id_e      gnt_id;
   alu_req_t     req0, req1, gnt_req;
   arb_id_e      rsp_id_q;
   logic [N-1:0] rsp_result_q;
   logic         rsp_zero_q;

   // Gating with rst_n keeps ready low while reset is held.
   assign can_accept = rst_n && ((state == RSP_EMPTY) || bus.rsp_ready);

   assign req0 = '{bus.req0_opcode, bus.req0_funct3, bus.req0_funct7, bus.req0_a, bus.req0_b};
   assign req1 = '{bus.req1_opcode, bus.req1_funct3, bus.req1_funct7, bus.req1_a, bus.req1_b};

   rr_arb2 u_rr_arb2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       ({bus.req1_valid, bus.req0_valid}),
      .en        (can_accept),
      .gnt_valid (accept),
      .gnt_id    (gnt_id)
   );

   always_comb begin
      gnt_req = '0;
      if (accept) gnt_req = (gnt_id == ARB_ID_AUX) ? req1 : req0;
   end

   assign bus.req0_ready = accept && (gnt_id == ARB_ID_PIPE);
   assign bus.req1_ready = accept && (gnt_id == ARB_ID_AUX);
   assign bus.alu_opcode = gnt_req.opcode;
   assign bus.alu_funct3 = gnt_req.funct3;
   assign bus.alu_funct7 = gnt_req.funct7;
   assign bus.alu_a      = gnt_req.a;
   assign bus.alu_b      = gnt_req.b;
   assign bus.alu_valid  = accept;

   always_comb begin
      state_nxt = state;
      case (state)
         RSP_EMPTY: if (accept) state_nxt = RSP_FULL;
         RSP_FULL:  if (!accept && bus.rsp_ready) state_nxt = RSP_EMPTY;
         default:   state_nxt = RSP_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= RSP_EMPTY;
         rsp_id_q     <= ARB_ID_PIPE;
         rsp_result_q <= '0;
         rsp_zero_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            rsp_id_q     <= gnt_id;
            rsp_result_q <= bus.alu_result;
            rsp_zero_q   <= bus.alu_zero;
         end
      end
   end

   assign bus.rsp_valid  = (state == RSP_FULL);
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_zero   = rsp_zero_q;

`ifdef ALU_ARB_PERF_EN
   logic conflict;

   assign conflict = bus.req0_valid && bus.req1_valid && can_accept;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_grant0   <= '0;
         perf_grant1   <= '0;
         perf_conflict <= '0;
      end else if (perf_clr) begin
         perf_grant0   <= '0;
         perf_grant1   <= '0;
         perf_conflict <= '0;
      end else begin
         perf_grant0   <= sat_inc(perf_grant0, bus.req0_ready);
         perf_grant1   <= sat_inc(perf_grant1, bus.req1_ready);
         perf_conflict <= sat_inc(perf_conflict, conflict);
      end
   end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed requests push hand-computed responses,
// a negedge monitor pops and compares each drained response.
module tb_alu_arbiter;
   import alu_arbiter_pkg::*;

   typedef struct {
      logic        id;
      logic [31:0] res;
      logic        zero;
   } exp_t;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];

   alu_arbiter_if #(.N(32)) bus ();

`ifdef ALU_ARB_PERF_EN
   logic        perf_clr;
   logic [15:0] perf_grant0, perf_grant1, perf_conflict;
`endif

   alu_arbiter #(.N(32)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
`ifdef ALU_ARB_PERF_EN
      .perf_clr      (perf_clr),
      .perf_grant0   (perf_grant0),
      .perf_grant1   (perf_grant1),
      .perf_conflict (perf_conflict),
`endif
      .bus           (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural ALU: ADD/SUB/XOR on OP, anything else returns 0.
   always_comb begin
      logic [31:0] r;
      r = '0;
      if (bus.alu_opcode == OPCODE_OP) begin
         case (bus.alu_funct3)
            F3_ADD_SUB: r = (bus.alu_funct7 == F7_ALT) ? bus.alu_a - bus.alu_b : bus.alu_a + bus.alu_b;
            F3_XOR:     r = bus.alu_a ^ bus.alu_b;
            default:    r = '0;
         endcase
      end
      bus.alu_result = r;
      bus.alu_zero   = (r == '0);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic id, input logic [31:0] res, input logic zero);
      exp_t e;
      e.id = id; e.res = res; e.zero = zero;
      sb_q.push_back(e);
   endtask

   task automatic set_req(input int p, input logic v, input logic [6:0] op, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
      if (p == 0) begin
         bus.req0_valid = v; bus.req0_opcode = op; bus.req0_funct3 = f3;
         bus.req0_funct7 = f7; bus.req0_a = a; bus.req0_b = b;
      end else begin
         bus.req1_valid = v; bus.req1_opcode = op; bus.req1_funct3 = f3;
         bus.req1_funct7 = f7; bus.req1_a = a; bus.req1_b = b;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected actual id=%0d result=%h required none", bus.rsp_id, bus.rsp_result);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
            chk("rsp_result", bus.rsp_result, e.res);
            chk("rsp_zero", 32'(bus.rsp_zero), 32'(e.zero));
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      bus.rsp_ready = 1'b1;
      set_req(0, 1'b1, OPCODE_OP, F3_ADD_SUB, F7_BASE, 32'd1, 32'd1);
      set_req(1, 1'b0, 7'd0, 3'd0, 7'd0, 32'd0, 32'd0);
`ifdef ALU_ARB_PERF_EN
      perf_clr = 1'b0;
`endif
      #2;
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("rst_rsp_id", 32'(bus.rsp_id), 0);
      chk("rst_rsp_result", bus.rsp_result, 0);
      chk("rst_rsp_zero", 32'(bus.rsp_zero), 0);
      chk("rst_no_ready0", 32'(bus.req0_ready), 0);
      set_req(0, 1'b0, 7'd0, 3'd0, 7'd0, 32'd0, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Port 0 ADD 5+3
      set_req(0, 1'b1, OPCODE_OP, F3_ADD_SUB, F7_BASE, 32'd5, 32'd3);
      @(negedge clk);
      chk("t1_ready0", 32'(bus.req0_ready), 1);
      chk("t1_alu_valid", 32'(bus.alu_valid), 1);
      push(1'b0, 32'd8, 1'b0);
      step();
      set_req(0, 1'b0, 7'd0, 3'd0, 7'd0, 32'd0, 32'd0);
      @(negedge clk);
      chk("t1_latency", 32'(bus.rsp_valid), 1);
      chk("t1_idle_alu_a", bus.alu_a, 0);
      step();

      // Port 1 XOR
      set_req(1, 1'b1, OPCODE_OP, F3_XOR, F7_BASE, 32'hFFFF0000, 32'h0F0F0F0F);
      @(negedge clk);
      chk("t4_ready1", 32'(bus.req1_ready), 1);
      chk("t4_ready0", 32'(bus.req0_ready), 0);
      push(1'b1, 32'hF0F00F0F, 1'b0);
      step();
      set_req(1, 1'b0, 7'd0, 3'd0, 7'd0, 32'd0, 32'd0);

      // Both valid, SUB 7-7, alternating grants starting at port 0
      set_req(0, 1'b1, OPCODE_OP, F3_ADD_SUB, F7_ALT, 32'd7, 32'd7);
      set_req(1, 1'b1, OPCODE_OP, F3_ADD_SUB, F7_ALT, 32'd7, 32'd7);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t2_ready0", 32'(bus.req0_ready), 32'((i % 2) == 0));
         chk("t2_ready1", 32'(bus.req1_ready), 32'((i % 2) == 1));
         push(1'(i % 2), 32'd0, 1'b1);
         step();
      end
      set_req(0, 1'b0, 7'd0, 3'd0, 7'd0, 32'd0, 32'd0);
      set_req(1, 1'b0, 7'd0, 3'd0, 7'd0, 32'd0, 32'd0);
      @(negedge clk);
      step();

      // Backpressure: hold response, then pass-through refill
      bus.rsp_ready = 1'b0;
      set_req(0, 1'b1, OPCODE_OP, F3_ADD_SUB, F7_BASE, 32'd1, 32'd2);
      set_req(1, 1'b1, OPCODE_OP, F3_ADD_SUB, F7_BASE, 32'd10, 32'd20);
      @(negedge clk);
      chk("t3_first_ready0", 32'(bus.req0_ready), 1);
      chk("t3_first_ready1", 32'(bus.req1_ready), 0);
      push(1'b0, 32'd3, 1'b0);
      step();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t3_hold_ready0", 32'(bus.req0_ready), 0);
         chk("t3_hold_ready1", 32'(bus.req1_ready), 0);
         chk("t3_hold_valid", 32'(bus.rsp_valid), 1);
         chk("t3_hold_result", bus.rsp_result, 32'd3);
         chk("t3_hold_id", 32'(bus.rsp_id), 0);
         step();
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk("t3_pass_ready1", 32'(bus.req1_ready), 1);
      chk("t3_pass_ready0", 32'(bus.req0_ready), 0);
      push(1'b1, 32'd30, 1'b0);
      step();
      set_req(0, 1'b0, 7'd0, 3'd0, 7'd0, 32'd0, 32'd0);
      set_req(1, 1'b0, 7'd0, 3'd0, 7'd0, 32'd0, 32'd0);
      @(negedge clk);
      chk("t3_refill_valid", 32'(bus.rsp_valid), 1);
      step();

      // Asynchronous reset with a response in flight
      bus.rsp_ready = 1'b0;
      set_req(0, 1'b1, OPCODE_OP, F3_ADD_SUB, F7_BASE, 32'd1, 32'd1);
      set_req(1, 1'b1, OPCODE_OP, F3_ADD_SUB, F7_BASE, 32'd2, 32'd2);
      @(negedge clk);
      chk("t5_pre_ready0", 32'(bus.req0_ready), 1);
      step();
      chk("t5_inflight", 32'(bus.rsp_valid), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("t5_async_valid", 32'(bus.rsp_valid), 0);
      chk("t5_async_result", bus.rsp_result, 0);
      chk("t5_rst_ready0", 32'(bus.req0_ready), 0);
      chk("t5_rst_ready1", 32'(bus.req1_ready), 0);
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      #2 rst_n = 1'b1;
      #1;
      chk("t5_post_ready0", 32'(bus.req0_ready), 1);
      chk("t5_post_ready1", 32'(bus.req1_ready), 0);
      push(1'b0, 32'd2, 1'b0);
      step();
      @(negedge clk);
      chk("t5_second_ready1", 32'(bus.req1_ready), 1);
      push(1'b1, 32'd4, 1'b0);
      step();
      set_req(0, 1'b0, 7'd0, 3'd0, 7'd0, 32'd0, 32'd0);
      set_req(1, 1'b0, 7'd0, 3'd0, 7'd0, 32'd0, 32'd0);
      @(negedge clk);
      step();

`ifdef ALU_ARB_PERF_EN
      perf_clr = 1'b1;
      step();
      perf_clr = 1'b0;
      set_req(0, 1'b1, OPCODE_OP, F3_ADD_SUB, F7_BASE, 32'd1, 32'd1);
      set_req(1, 1'b1, OPCODE_OP, F3_ADD_SUB, F7_BASE, 32'd3, 32'd3);
      @(negedge clk);
      chk("pf_ready0", 32'(bus.req0_ready), 1);
      push(1'b0, 32'd2, 1'b0);
      step();
      @(negedge clk);
      chk("pf_ready1", 32'(bus.req1_ready), 1);
      push(1'b1, 32'd6, 1'b0);
      step();
      set_req(1, 1'b0, 7'd0, 3'd0, 7'd0, 32'd0, 32'd0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("pf_solo_ready0", 32'(bus.req0_ready), 1);
         push(1'b0, 32'd2, 1'b0);
         step();
      end
      set_req(0, 1'b0, 7'd0, 3'd0, 7'd0, 32'd0, 32'd0);
      set_req(1, 1'b1, OPCODE_OP, F3_ADD_SUB, F7_BASE, 32'd3, 32'd3);
      @(negedge clk);
      chk("pf_solo_ready1", 32'(bus.req1_ready), 1);
      push(1'b1, 32'd6, 1'b0);
      step();
      set_req(1, 1'b0, 7'd0, 3'd0, 7'd0, 32'd0, 32'd0);
      chk("pf_grant0", 32'(perf_grant0), 3);
      chk("pf_grant1", 32'(perf_grant1), 2);
      chk("pf_conflict", 32'(perf_conflict), 2);
      perf_clr = 1'b1;
      step();
      perf_clr = 1'b0;
      chk("pf_clr_grant0", 32'(perf_grant0), 0);
      chk("pf_clr_grant1", 32'(perf_grant1), 0);
      chk("pf_clr_conflict", 32'(perf_conflict), 0);
`endif

      repeat (3) step();
      chk("sb_drain", 32'(sb_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
